// File: rtl/sticky_status_reg.sv
`default_nettype none
// ============================================================================
//  Module      : sticky_status_reg
//  Description : Parametrised sticky-status register. Sticky bits capture
//                event pulses until software clears them through a masked,
//                delayed clear sequence (IDLE -> HOLD -> CLEAR). During HOLD
//                the bits selected for clearing are frozen. In CLEAR a new
//                event on a selected bit wins over the clear, so no event is
//                lost. Non-sticky bits are registered pass-through. The irq
//                output is the registered OR of enabled status bits.
//  Options     : `define STICKY_STATUS_OVF_EN adds the ovf_out overflow
//                flags (an event seen on an already-set sticky bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module sticky_status_reg #(
    parameter int               WIDTH       = 13,
    parameter logic [WIDTH-1:0] STICKY_MASK = 13'h126D,
    parameter int               CLR_DELAY   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clear_req,
    input  logic [WIDTH-1:0] clear_mask,
    input  logic [WIDTH-1:0] irq_en,
    output logic [WIDTH-1:0] data_out,
    output logic             clear_busy,
    output logic             clear_done,
    output logic             irq
`ifdef STICKY_STATUS_OVF_EN
    ,
    output logic [WIDTH-1:0] ovf_out
`endif
);

    // State encoding of the clear sequencer
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_hold  = 2'd1;
    localparam logic [1:0] c_st_clear = 2'd2;

    // The counter is 4 bits wide: CLR_DELAY is limited to 0..15
    localparam logic [3:0] c_clr_delay  = 4'(CLR_DELAY);
    localparam bit         c_delay_zero = (CLR_DELAY == 0);

    logic [1:0]       r_state;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_pend;
    logic [WIDTH-1:0] r_data;
    logic             r_irq;

    logic [WIDTH-1:0] w_hold_mask;
    logic [WIDTH-1:0] w_clr_mask;
    logic [WIDTH-1:0] w_data_next;

    // Per-bit next status: pass-through, accumulate, freeze or set-wins clear
    always_comb begin
        w_hold_mask = (r_state == c_st_hold)  ? r_pend : '0;
        w_clr_mask  = (r_state == c_st_clear) ? r_pend : '0;
        w_data_next = (~STICKY_MASK & data_in)
                    | (STICKY_MASK & ~w_hold_mask & ~w_clr_mask & (data_in | r_data))
                    | (w_hold_mask & r_data)
                    | (w_clr_mask  & data_in);
    end

    // Clear sequencer: latch the pending mask, count out HOLD, one CLEAR cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_pend  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (clear_req) begin
                        r_pend  <= clear_mask & STICKY_MASK;
                        r_cnt   <= c_clr_delay;
                        r_state <= c_delay_zero ? c_st_clear : c_st_hold;
                    end
                end
                c_st_hold: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= c_st_clear;
                    end
                end
                c_st_clear: begin
                    r_pend  <= '0;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Status register and interrupt (irq lags data_out by one cycle)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_data <= w_data_next;
            r_irq  <= |(r_data & irq_en);
        end
    end

`ifdef STICKY_STATUS_OVF_EN
    logic [WIDTH-1:0] r_ovf;
    logic [WIDTH-1:0] w_ovf_hit;

    // An overflow is an event arriving on a sticky bit that is already set
    always_comb begin
        w_ovf_hit = STICKY_MASK & r_data & data_in;
    end

    // Overflow flags: set in IDLE/HOLD, cleared with the status bit in CLEAR
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= '0;
        end else if (r_state == c_st_clear) begin
            r_ovf <= (r_ovf & ~r_pend) | (r_pend & w_ovf_hit);
        end else begin
            r_ovf <= r_ovf | w_ovf_hit;
        end
    end

    assign ovf_out = r_ovf;
`endif

    assign data_out   = r_data;
    assign irq        = r_irq;
    assign clear_busy = (r_state == c_st_hold) || (r_state == c_st_clear);
    assign clear_done = (r_state == c_st_clear);

endmodule
`default_nettype wire

// File: tb/tb_sticky_status_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sticky_status_reg
//  Description : Self-checking bench for sticky_status_reg. Two instances
//                (CLR_DELAY = 2 and CLR_DELAY = 0) share one stimulus stream
//                and are compared every cycle against a sequence-position
//                reference model, plus directed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sticky_status_reg;

    localparam int          W    = 13;
    localparam logic [12:0] SM   = 13'h126D;
    localparam int          DA   = 2;
    localparam int          DB   = 0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  data_in    = '0;
    logic          clear_req  = 1'b0;
    logic [W-1:0]  clear_mask = '0;
    logic [W-1:0]  irq_en     = '0;

    logic [W-1:0]  a_out, b_out;
    logic          a_busy, a_done, a_irq;
    logic          b_busy, b_done, b_irq;
`ifdef STICKY_STATUS_OVF_EN
    logic [W-1:0]  a_ovf, b_ovf;
`endif

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    sticky_status_reg #(.WIDTH(W), .STICKY_MASK(SM), .CLR_DELAY(DA)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .clear_req  (clear_req),
        .clear_mask (clear_mask),
        .irq_en     (irq_en),
        .data_out   (a_out),
        .clear_busy (a_busy),
        .clear_done (a_done),
        .irq        (a_irq)
`ifdef STICKY_STATUS_OVF_EN
        ,
        .ovf_out    (a_ovf)
`endif
    );

    sticky_status_reg #(.WIDTH(W), .STICKY_MASK(SM), .CLR_DELAY(DB)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .clear_req  (clear_req),
        .clear_mask (clear_mask),
        .irq_en     (irq_en),
        .data_out   (b_out),
        .clear_busy (b_busy),
        .clear_done (b_done),
        .irq        (b_irq)
`ifdef STICKY_STATUS_OVF_EN
        ,
        .ovf_out    (b_ovf)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: each instance tracks whether a clear sequence is
    // running and the 1-based cycle position s within it. Positions
    // 1..D are HOLD, position D+1 is the CLEAR cycle.
    // ------------------------------------------------------------------
    logic [12:0] m_out  [2];
    logic [12:0] m_pend [2];
    logic        m_irq  [2];
    bit          m_act  [2];
    int          m_s    [2];

    function automatic int d_of(input int k);
        return (k == 0) ? DA : DB;
    endfunction

    function automatic logic [12:0] f_next(input logic [12:0] cur, input logic [12:0] din,
                                           input logic [12:0] pend, input bit act,
                                           input int s, input int d);
        logic [12:0] r;
        r = '0;
        for (int b = 0; b < 13; b++) begin
            if (!SM[b])                      r[b] = din[b];
            else if (act && pend[b] && s <= d) r[b] = cur[b];
            else if (act && pend[b])         r[b] = din[b];
            else                             r[b] = din[b] | cur[b];
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_out[k]  <= '0;
                m_pend[k] <= '0;
                m_irq[k]  <= 1'b0;
                m_act[k]  <= 1'b0;
                m_s[k]    <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_out[k] <= f_next(m_out[k], data_in, m_pend[k], m_act[k], m_s[k], d_of(k));
                m_irq[k] <= |(m_out[k] & irq_en);
                if (m_act[k]) begin
                    if (m_s[k] == d_of(k) + 1) m_act[k] <= 1'b0;
                    else                       m_s[k]   <= m_s[k] + 1;
                end else if (clear_req) begin
                    m_act[k]  <= 1'b1;
                    m_s[k]    <= 1;
                    m_pend[k] <= clear_mask & SM;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("a_data_out", 32'(a_out), 32'(m_out[0]));
            check("a_busy", 32'(a_busy), 32'(m_act[0]));
            check("a_done", 32'(a_done), 32'(m_act[0] && m_s[0] == DA + 1));
            check("a_irq", 32'(a_irq), 32'(m_irq[0]));
            check("b_data_out", 32'(b_out), 32'(m_out[1]));
            check("b_busy", 32'(b_busy), 32'(m_act[1]));
            check("b_done", 32'(b_done), 32'(m_act[1] && m_s[1] == DB + 1));
            check("b_irq", 32'(b_irq), 32'(m_irq[1]));
        end
    end

    int busy_cnt, done_cnt;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_a_out", 32'(a_out), 32'h0);
        check("rst_a_ctl", {29'd0, a_busy, a_done, a_irq}, 32'h0);
        check("rst_b_out", 32'(b_out), 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        chk_en = 1'b1;

        // Accumulate on sticky bit 0, pass-through on bit 1
        @(negedge clk); data_in = 13'h0001;
        @(negedge clk); data_in = 13'h0000;
        check("acc_bit0_set", 32'(a_out[0]), 32'h1);
        @(negedge clk);
        check("acc_bit0_hold", 32'(a_out[0]), 32'h1);
        data_in = 13'h0002;
        @(negedge clk); data_in = 13'h0000;
        check("pass_bit1_on", 32'(a_out[1]), 32'h1);
        @(negedge clk);
        check("pass_bit1_off", 32'(a_out[1]), 32'h0);

        // Masked clear of bits 0 and 2
        data_in = 13'h126D;
        @(negedge clk); data_in = 13'h0000;
        check("full_pattern", 32'(a_out), 32'h126D);
        clear_req = 1'b1; clear_mask = 13'h0005;
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            clear_req = 1'b0;
            if (a_busy) busy_cnt++;
            if (a_done) done_cnt++;
            if (i == 0) check("b_done_delay0", 32'(b_done), 32'h1);
            if (i == 1) check("b_cleared", 32'(b_out), 32'h1268);
            if (i == 2) check("a_done_third", 32'(a_done), 32'h1);
            if (i == 3) check("a_cleared", 32'(a_out), 32'h1268);
        end
        check("a_busy_cycles", 32'(busy_cnt), 32'd3);
        check("a_done_count", 32'(done_cnt), 32'd1);

        // Event during HOLD is lost to the clear; bit stays frozen until CLEAR
        data_in = 13'h0001;
        @(negedge clk); data_in = 13'h0000;
        clear_req = 1'b1; clear_mask = 13'h0001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            clear_req = 1'b0;
            data_in = (i == 0) ? 13'h0001 : 13'h0000;
            if (i <= 2) check("hold_frozen", 32'(a_out[0]), 32'h1);
            if (i == 3) check("hold_cleared", 32'(a_out[0]), 32'h0);
        end

        // Event during CLEAR wins
        data_in = 13'h0001;
        @(negedge clk); data_in = 13'h0000;
        clear_req = 1'b1; clear_mask = 13'h0001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            clear_req = 1'b0;
            data_in = (i == 2) ? 13'h0001 : 13'h0000;
            if (i >= 3) check("set_wins", 32'(a_out[0]), 32'h1);
        end

        // Second request during HOLD is ignored
        clear_req = 1'b1; clear_mask = 13'h0008;
        done_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            clear_req = (i == 1);
            if (a_done) done_cnt++;
        end
        check("ignored_req_done", 32'(done_cnt), 32'd1);

        // Interrupt: clear bit 9 first, then pulse it
        irq_en = 13'h0200;
        clear_req = 1'b1; clear_mask = 13'h0200;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            clear_req = 1'b0;
        end
        check("irq_idle", 32'(a_irq), 32'h0);
        data_in = 13'h0200;
        @(negedge clk); data_in = 13'h0000;
        check("irq_bit9", 32'(a_out[9]), 32'h1);
        check("irq_lag", 32'(a_irq), 32'h0);
        @(negedge clk);
        check("irq_set", 32'(a_irq), 32'h1);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            data_in    = 13'($urandom & $urandom & $urandom);
            clear_req  = ($urandom_range(0, 3) == 0);
            clear_mask = 13'($urandom);
            if ($urandom_range(0, 15) == 0) irq_en = 13'($urandom);
        end

        // Reset in the middle of HOLD
        @(negedge clk);
        data_in = 13'h1FFF; clear_req = 1'b0;
        @(negedge clk);
        data_in = 13'h0000; clear_req = 1'b1; clear_mask = 13'h1FFF; irq_en = 13'h1FFF;
        @(negedge clk);
        clear_req = 1'b0;
        check("pre_rst_busy", 32'(a_busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("midrst_a_out", 32'(a_out), 32'h0);
        check("midrst_a_ctl", {29'd0, a_busy, a_done, a_irq}, 32'h0);
        check("midrst_b", {16'd0, b_out, b_busy, b_done, b_irq}, 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 32'(a_busy), 32'h0);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sticky_status_reg.md
# sticky_status_reg

Parametrised sticky-status register for peripheral interrupt and status reporting. It captures per-bit event pulses into sticky flags and passes non-sticky bits straight through, registered. A masked, delayed clear sequence lets software clear selected flags without losing events that arrive during the clear. It supersedes the fixed 13-bit status register and adds selective clear, set-wins-over-clear semantics, a programmable clear delay and an interrupt output.

## Interface
- `WIDTH`, default 13: number of status bits.
- `STICKY_MASK`, default `13'h126D` (bits 0,2,3,5,6,9,12): a 1 makes the bit sticky; a 0 makes it a registered pass-through.
- `CLR_DELAY`, default 2, legal range 0..15: cycles spent in HOLD before the clear takes effect.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `data_in`  in  WIDTH  raw status/event inputs, sampled every cycle.
- `clear_req`  in  1  single-cycle clear request; honoured only in IDLE.
- `clear_mask`  in  WIDTH  bits to clear; sampled together with `clear_req`.
- `irq_en`  in  WIDTH  per-bit interrupt enable.
- `data_out`  out  WIDTH  registered status.
- `clear_busy`  out  1  high while in HOLD or CLEAR.
- `clear_done`  out  1  one-cycle pulse while in CLEAR.
- `irq`  out  1  registered OR of (`data_out` & `irq_en`).
- `ovf_out`  out  WIDTH  overflow flags; present only with `STICKY_STATUS_OVF_EN`.

## Operation
- Non-sticky bits (STICKY_MASK=0):
  - `data_out[i]` <= `data_in[i]` every cycle, in every state.
  - They are never affected by a clear.
- Sticky bits (STICKY_MASK=1) in IDLE: `data_out[i]` <= `data_in[i] | data_out[i]`.
- On `clear_req` in IDLE:
  - Latch `pend` = `clear_mask & STICKY_MASK`.
  - Load the counter with CLR_DELAY.
  - Go to HOLD, or go directly to CLEAR if CLR_DELAY=0.
- HOLD:
  - Bits with `pend[i]`=1 are frozen.
  - All other sticky bits keep accumulating.
  - The counter decrements each cycle. The cycle in which it reads 1 moves the FSM to CLEAR, so HOLD lasts exactly CLR_DELAY cycles.
- CLEAR, one cycle:
  - For each `pend[i]`=1: `data_out[i]` <= `data_in[i]`. A new event in the clear cycle wins, so no event is lost.
  - Unmasked sticky bits accumulate.
  - `clear_done`=1.
  - Next state is IDLE.
- `clear_req` in HOLD or CLEAR is ignored (not queued). A request in the cycle after CLEAR is accepted normally.
- A `pend` of all zeros still runs the full sequence with `clear_done`, and no bit changes.
- States are IDLE, HOLD, CLEAR; encoding is free. The FSM holds no terminal state.
- `irq` <= |(`data_out` & `irq_en`), one cycle behind `data_out`. Changing `irq_en` affects `irq` on the next edge.

## Timing
- Reset (async, immediate) clears `data_out`, `pend`, the counter, `irq` and `ovf_out` to 0. The FSM goes to IDLE, and `clear_busy`/`clear_done` are 0.
- Reset mid-sequence aborts the clear. After release the FSM is in IDLE with no pending clear.
- Latency from `data_in` to `data_out` is 1 cycle. Latency from `data_out` to `irq` is 1 cycle.
- Clear latency:
  - `clear_req` accepted at edge N.
  - `clear_busy` is high from N+1.
  - `clear_done` is high in cycle N+1+CLR_DELAY.
  - The cleared value is visible after edge N+2+CLR_DELAY.
- `clear_busy` and `clear_done` are decoded from the state register only, with no combinational path from inputs.

## Configuration
- `STICKY_STATUS_OVF_EN` defined:
  - Adds the `ovf_out` port and register.
  - `ovf_out[i]` sets when a sticky bit has `data_out[i]`=1 and `data_in[i]`=1 in the same cycle, in IDLE or HOLD.
  - `ovf_out[i]` is cleared in CLEAR together with `data_out[i]` when `pend[i]`=1, with the same set-wins rule.
- `STICKY_STATUS_OVF_EN` undefined: no `ovf_out` port and no overflow logic; all other behaviour is identical.

## Test plan
- Accumulate: pulse `data_in`=0x0001 for one cycle, then drive 0 → `data_out[0]` stays 1; pulse bit 1 (non-sticky) → `data_out[1]` is 1 for exactly one cycle.
- Masked clear, CLR_DELAY=2:
  - Stimulus: `data_out`=0x126D; `clear_req` with `clear_mask`=0x0005; `data_in`=0.
  - Required: `clear_busy` high for 3 cycles, `clear_done` on the 3rd.
  - Required: after the following edge `data_out`=0x1268.
- Set-wins and hold:
  - Stimulus: clear bit 0; drive `data_in[0]`=1 in a HOLD cycle only.
  - Required: bit 0 stays 1 and frozen through HOLD, then is cleared to 0.
  - Stimulus: repeat with `data_in[0]`=1 during CLEAR.
  - Required: bit 0 reads 1 after the sequence.
- Ignored request and CLR_DELAY=0:
  - Stimulus: second `clear_req` during HOLD.
  - Required: exactly one `clear_done`.
  - Stimulus: CLR_DELAY=0.
  - Required: `clear_done` in the cycle right after the request.
- IRQ and reset:
  - Stimulus: `irq_en`=0x0200, `data_in[9]` pulse.
  - Required: `irq`=1 one cycle after `data_out[9]`.
  - Stimulus: assert `rst` mid-HOLD.
  - Required: all outputs 0 immediately, FSM in IDLE.
- With `STICKY_STATUS_OVF_EN`: pulse `data_in[3]` twice, 3 cycles apart → `ovf_out`=0x0008; masked clear of bit 3 → `ovf_out`=0.
